game_fsm: RTL and testbench

GAME_FSM -- requirements
Module: game_fsm

---
 rtl/game_fsm.sv | 167 ++++++++++++++++
 tb/tb_game_fsm.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_fsm.sv
// Snake game sequencer: paces the snake with a tick divider, issues one-cycle
// datapath commands per step and tracks score, direction and end-of-game state.
module game_fsm #(
    parameter int unsigned        TICK_W   = 16,
    parameter logic [TICK_W-1:0]  TICK_DIV = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] dir_in,
    input  logic       wall_hit,
    input  logic       body_hit,
    input  logic       apple_hit,
    input  logic [6:0] length,
    output logic       step_en,
    output logic       shift_en,
    output logic       grow_en,
    output logic       apple_load,
    output logic       clr_en,
    output logic [3:0] dir_q,
    output logic       game_over,
    output logic       win,
    output logic [6:0] score,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_MOVE   = 3'd2,
        S_CHECK  = 3'd3,
        S_UPDATE = 3'd4,
        S_OVER   = 3'd5,
        S_WON    = 3'd6
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_DIV - 1'b1;
    localparam logic [3:0]        DIR_RIGHT = 4'b1000;

    state_t            r_state;
    logic [TICK_W-1:0] r_tick;
    logic              r_start_d;
    logic              r_grow;
    logic [6:0]        r_score;
    logic [3:0]        r_dir_q;
    logic [3:0]        r_dir_pend;

    state_t            w_next_state;
    logic [TICK_W-1:0] w_tick_nxt;
    logic              w_grow_nxt;
    logic [6:0]        w_score_nxt;
    logic [3:0]        w_dir_q_nxt;
    logic [3:0]        w_dir_pend_nxt;
    logic              w_start_rise;
    logic              w_dir_onehot;
    logic              w_dir_ok;
    logic              w_playing;

    // Reset wins over a coincident start edge, so the edge is masked here.
    assign w_start_rise = start & ~r_start_d & ~reset;

    // Reversal is judged against the committed direction; rotating by two
    // positions maps up<->down and left<->right.
    assign w_dir_onehot = (dir_in != 4'b0000) && ((dir_in & (dir_in - 4'd1)) == 4'b0000);
    assign w_dir_ok     = w_dir_onehot && (dir_in != {r_dir_q[1:0], r_dir_q[3:2]});

    assign w_playing = (r_state == S_WAIT) || (r_state == S_MOVE) ||
                       (r_state == S_CHECK) || (r_state == S_UPDATE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_start_d  <= 1'b0;
            r_grow     <= 1'b0;
            r_score    <= 7'd0;
            r_dir_q    <= DIR_RIGHT;
            r_dir_pend <= DIR_RIGHT;
        end else begin
            r_state    <= w_next_state;
            r_tick     <= w_tick_nxt;
            r_start_d  <= start;
            r_grow     <= w_grow_nxt;
            r_score    <= w_score_nxt;
            r_dir_q    <= w_dir_q_nxt;
            r_dir_pend <= w_dir_pend_nxt;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_tick_nxt     = r_tick;
        w_grow_nxt     = r_grow;
        w_score_nxt    = r_score;
        w_dir_q_nxt    = r_dir_q;
        w_dir_pend_nxt = r_dir_pend;
        step_en        = 1'b0;
        shift_en       = 1'b0;
        grow_en        = 1'b0;
        apple_load     = 1'b0;
        clr_en         = 1'b0;

        if (w_playing && w_dir_ok) begin
            w_dir_pend_nxt = dir_in;
        end

        case (r_state)
            S_IDLE, S_OVER, S_WON: begin
                if (w_start_rise) begin
                    clr_en         = 1'b1;
                    w_score_nxt    = 7'd0;
                    w_tick_nxt     = '0;
                    w_grow_nxt     = 1'b0;
                    w_dir_q_nxt    = DIR_RIGHT;
                    w_dir_pend_nxt = DIR_RIGHT;
                    w_next_state   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (start) begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_nxt   = '0;
                        w_next_state = S_MOVE;
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
            end
            S_MOVE: begin
                step_en      = 1'b1;
                w_dir_q_nxt  = r_dir_pend;
                w_next_state = S_CHECK;
            end
            S_CHECK: begin
                if (wall_hit || body_hit) begin
                    w_next_state = S_OVER;
                end else begin
                    w_grow_nxt   = apple_hit;
                    w_next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (r_grow) begin
                    grow_en    = 1'b1;
                    apple_load = 1'b1;
                    if (r_score != 7'd127) begin
                        w_score_nxt = r_score + 7'd1;
                    end
                    w_next_state = (length == 7'd126) ? S_WON : S_WAIT;
                end else begin
                    shift_en     = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign dir_q     = r_dir_q;
    assign score     = r_score;
    assign game_over = (r_state == S_OVER);
    assign win       = (r_state == S_WON);
    assign state     = r_state;

endmodule

// File: tb/tb_game_fsm.sv
// Bench for game_fsm: behavioural game model with a per-cycle expected queue,
// directed scenarios with literal expectations, then randomized play.
module tb_game_fsm;

    localparam int TICK_W = 16;
    localparam int TDIV   = 4;
    localparam int OW     = 21;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] dir_in;
    logic       wall_hit;
    logic       body_hit;
    logic       apple_hit;
    logic [6:0] length;
    logic       step_en;
    logic       shift_en;
    logic       grow_en;
    logic       apple_load;
    logic       clr_en;
    logic [3:0] dir_q;
    logic       game_over;
    logic       win;
    logic [6:0] score;
    logic [2:0] state;

    game_fsm #(.TICK_W(TICK_W), .TICK_DIV(16'd4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dir_in    (dir_in),
        .wall_hit  (wall_hit),
        .body_hit  (body_hit),
        .apple_hit (apple_hit),
        .length    (length),
        .step_en   (step_en),
        .shift_en  (shift_en),
        .grow_en   (grow_en),
        .apple_load(apple_load),
        .clr_en    (clr_en),
        .dir_q     (dir_q),
        .game_over (game_over),
        .win       (win),
        .score     (score),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 playing, 2 lost, 3 won. While playing, m_post is
    // 0 while waiting for ticks, then 1/2/3 for the three cycles of a step.
    int         m_mode;
    int         m_ticks;
    int         m_post;
    int         m_score;
    bit         m_grow;
    bit         m_prev;
    logic [3:0] m_dir;
    logic [3:0] m_pend;

    logic [OW-1:0] exp_q[$];
    int n_total;
    int n_bad;

    function automatic logic [3:0] opposite(input logic [3:0] d);
        case (d)
            4'b0001: return 4'b0100;
            4'b0100: return 4'b0001;
            4'b0010: return 4'b1000;
            4'b1000: return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int model_state();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 5;
        if (m_mode == 3) return 6;
        return (m_post == 0) ? 1 : m_post + 1;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_ticks = 0;
        m_post  = 0;
        m_score = 0;
        m_grow  = 0;
        m_prev  = 0;
        m_dir   = 4'b1000;
        m_pend  = 4'b1000;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        logic [OW-1:0] e;
        logic [OW-1:0] a;
        e = exp_q.pop_front();
        a = {state, score, dir_q, game_over, win, step_en, shift_en, grow_en, apple_load, clr_en};
        chk("state", 32'(a[20:18]), 32'(e[20:18]));
        chk("score", 32'(a[17:11]), 32'(e[17:11]));
        chk("dir_q", 32'(a[10:7]), 32'(e[10:7]));
        chk("game_over", 32'(a[6]), 32'(e[6]));
        chk("win", 32'(a[5]), 32'(e[5]));
        chk("step_en", 32'(a[4]), 32'(e[4]));
        chk("shift_en", 32'(a[3]), 32'(e[3]));
        chk("grow_en", 32'(a[2]), 32'(e[2]));
        chk("apple_load", 32'(a[1]), 32'(e[1]));
        chk("clr_en", 32'(a[0]), 32'(e[0]));
    endtask

    task automatic model_step(input bit r, input bit s, input logic [3:0] d, input bit w,
                              input bit b, input bit a, input logic [6:0] l, input bit rise);
        logic [3:0] newp;
        if (r) begin
            model_reset();
            return;
        end
        m_prev = s;
        if (m_mode != 1) begin
            if (rise) begin
                m_mode  = 1;
                m_ticks = 0;
                m_post  = 0;
                m_score = 0;
                m_grow  = 0;
                m_dir   = 4'b1000;
                m_pend  = 4'b1000;
            end
        end else begin
            newp = m_pend;
            if ($countones(d) == 1 && d != opposite(m_dir)) newp = d;
            case (m_post)
                0: if (s) begin
                    m_ticks++;
                    if (m_ticks == TDIV) begin
                        m_ticks = 0;
                        m_post  = 1;
                    end
                end
                1: begin
                    m_dir  = m_pend;
                    m_post = 2;
                end
                2: if (w || b) begin
                    m_mode = 2;
                    m_post = 0;
                end else begin
                    m_grow = a;
                    m_post = 3;
                end
                default: begin
                    if (m_grow) begin
                        if (m_score < 127) m_score++;
                        if (l == 7'd126) m_mode = 3;
                    end
                    m_post = 0;
                end
            endcase
            m_pend = newp;
        end
    endtask

    // One clock: drive inputs after the falling edge, check outputs, advance model.
    task automatic cyc(input bit r, input bit s, input logic [3:0] d, input bit w,
                       input bit b, input bit a, input logic [6:0] l);
        bit play;
        bit rise;
        @(negedge clk);
        reset = r; start = s; dir_in = d;
        wall_hit = w; body_hit = b; apple_hit = a; length = l;
        #1;
        rise = s && !m_prev && !r;
        play = (m_mode == 1);
        exp_q.push_back({3'(model_state()), 7'(m_score), m_dir,
                         m_mode == 2, m_mode == 3,
                         play && m_post == 1,
                         play && m_post == 3 && !m_grow,
                         play && m_post == 3 && m_grow,
                         play && m_post == 3 && m_grow,
                         !play && rise});
        compare_outputs();
        model_step(r, s, d, w, b, a, l, rise);
    endtask

    task automatic idle_cyc();
        cyc(0, 1, 4'b0000, 0, 0, 0, 7'd5);
    endtask

    task automatic goto_state(input int target);
        int guard;
        guard = 0;
        while (model_state() != target && guard < 64) begin
            idle_cyc();
            guard++;
        end
        chk("goto_bound", 32'(model_state()), 32'(target));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nsteps;
        bit rs, rw, rb, ra;
        logic [3:0] rd;
        logic [6:0] rl;
        n_total = 0;
        n_bad   = 0;
        reset = 1; start = 0; dir_in = 0;
        wall_hit = 0; body_hit = 0; apple_hit = 0; length = 7'd5;
        repeat (2) @(posedge clk);
        model_reset();

        // reset beats a coincident start edge, then reset state
        cyc(1, 1, 4'b0000, 0, 0, 0, 7'd5);
        chk("rst_prio_clr", 32'(clr_en), 32'd0);
        cyc(0, 0, 4'b0000, 0, 0, 0, 7'd5);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_dir", 32'(dir_q), 32'h8);
        chk("rst_score", 32'(score), 32'd0);

        // start edge, first step after four WAIT cycles, then a 7-cycle period
        cyc(0, 1, 4'b0000, 0, 0, 0, 7'd5);
        chk("clr_lit", 32'(clr_en), 32'd1);
        for (int i = 0; i < 4; i++) begin
            idle_cyc();
            chk("wait_state", 32'(state), 32'd1);
        end
        idle_cyc();
        chk("step_lit", 32'(step_en), 32'd1);
        chk("move_state", 32'(state), 32'd2);
        nsteps = 0;
        for (int i = 0; i < 7; i++) begin
            idle_cyc();
            if (step_en) nsteps++;
        end
        chk("period7_last", 32'(step_en), 32'd1);
        chk("period7_count", 32'(nsteps), 32'd1);
        chk("period7_dir", 32'(dir_q), 32'h8);

        // apple eaten
        goto_state(3);
        cyc(0, 1, 4'b0000, 0, 0, 1, 7'd5);
        idle_cyc();
        chk("apple_grow", 32'(grow_en), 32'd1);
        chk("apple_load", 32'(apple_load), 32'd1);
        chk("apple_noshift", 32'(shift_en), 32'd0);
        idle_cyc();
        chk("apple_score", 32'(score), 32'd1);
        chk("apple_wait", 32'(state), 32'd1);

        // reversal and non-one-hot requests ignored, a legal turn committed
        cyc(0, 1, 4'b0010, 0, 0, 0, 7'd5);
        cyc(0, 1, 4'b0011, 0, 0, 0, 7'd5);
        goto_state(2);
        idle_cyc();
        idle_cyc();
        chk("dir_hold", 32'(dir_q), 32'h8);
        cyc(0, 1, 4'b0001, 0, 0, 0, 7'd5);
        goto_state(2);
        idle_cyc();
        idle_cyc();
        chk("dir_up", 32'(dir_q), 32'h1);

        // start low in WAIT freezes the tick count
        goto_state(4);
        idle_cyc();
        idle_cyc();
        nsteps = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 4'b0000, 0, 0, 0, 7'd5);
            if (step_en) nsteps++;
        end
        chk("frozen_steps", 32'(nsteps), 32'd0);
        chk("frozen_state", 32'(state), 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle_cyc();
            if (step_en) nsteps++;
        end
        chk("resume_nostep", 32'(nsteps), 32'd0);
        idle_cyc();
        chk("resume_step", 32'(step_en), 32'd1);

        // reset in CHECK
        cyc(1, 1, 4'b0000, 1, 0, 0, 7'd5);
        cyc(0, 0, 4'b0000, 0, 0, 0, 7'd5);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_dir", 32'(dir_q), 32'h8);
        chk("midrst_cmds", 32'({step_en, shift_en, grow_en, apple_load, clr_en, game_over, win}), 32'd0);

        // wall beats apple, score kept, restart from OVER
        cyc(0, 1, 4'b0000, 0, 0, 0, 7'd5);
        goto_state(3);
        cyc(0, 1, 4'b0000, 0, 0, 1, 7'd5);
        goto_state(3);
        cyc(0, 1, 4'b0000, 1, 0, 1, 7'd5);
        idle_cyc();
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_nogrow", 32'(grow_en), 32'd0);
        chk("over_state", 32'(state), 32'd5);
        chk("over_score", 32'(score), 32'd1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 4'b0001, 1, 1, 1, 7'd126);
        cyc(0, 0, 4'b0000, 0, 0, 0, 7'd5);
        cyc(0, 1, 4'b0000, 0, 0, 0, 7'd5);
        chk("restart_clr", 32'(clr_en), 32'd1);
        idle_cyc();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_score", 32'(score), 32'd0);

        // win on the apple that fills the board
        goto_state(3);
        cyc(0, 1, 4'b0000, 0, 0, 1, 7'd126);
        cyc(0, 1, 4'b0000, 0, 0, 0, 7'd126);
        chk("win_grow", 32'(grow_en), 32'd1);
        idle_cyc();
        chk("win_flag", 32'(win), 32'd1);
        chk("win_state", 32'(state), 32'd6);
        nsteps = 0;
        for (int i = 0; i < 20; i++) begin
            idle_cyc();
            if (step_en) nsteps++;
        end
        chk("win_nostep", 32'(nsteps), 32'd0);

        // score saturates at 127
        cyc(0, 0, 4'b0000, 0, 0, 0, 7'd5);
        cyc(0, 1, 4'b0000, 0, 0, 0, 7'd5);
        for (int i = 0; i < 130; i++) begin
            goto_state(3);
            cyc(0, 1, 4'b0000, 0, 0, 1, 7'd5);
        end
        idle_cyc();
        idle_cyc();
        chk("score_sat", 32'(score), 32'd127);

        // randomized play
        for (int i = 0; i < 4000; i++) begin
            rs = ($urandom_range(0, 9) != 0);
            rd = ($urandom_range(0, 1) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            rw = ($urandom_range(0, 29) == 0);
            rb = ($urandom_range(0, 29) == 0);
            ra = ($urandom_range(0, 3) == 0);
            rl = ($urandom_range(0, 3) == 0) ? 7'd126 : 7'($urandom_range(0, 127));
            cyc($urandom_range(0, 199) == 0, rs, rd, rw, rb, ra, rl);
        end
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
